// File: rtl/alu_issue_ctrl.sv
// Issue stage ahead of the two-cycle registered ALU.
// Incoming requests pass through a small FIFO. At most one request per cycle
// goes to the ALU, and only while the downstream result buffer has credits.
module alu_issue_ctrl #(
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CREDITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_vld,
  output logic                     req_rdy,
  input  logic [1:0]               req_op,
  input  logic [WIDTH-1:0]         req_a,
  input  logic [WIDTH-1:0]         req_b,
  output logic                     alu_vld,
  output logic [1:0]               alu_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  input  logic                     credit_ret,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [$clog2(CREDITS):0] credit_cnt,
  output logic                     err_illegal,
  output logic                     err_credit
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned CRD_W = $clog2(CREDITS) + 1;

  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;
  localparam logic [1:0] OP_ILL = 2'd3;

  // Request storage. Only add and sub entries are ever written.
  logic [1:0]       mem_op [DEPTH];
  logic [WIDTH-1:0] mem_a  [DEPTH];
  logic [WIDTH-1:0] mem_b  [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             accept_c;
  logic             push_c;
  logic             illegal_c;
  logic             issue_c;
  logic             credit_ovf_c;
  logic [CNT_W-1:0] count_nxt;
  logic [CRD_W-1:0] credit_nxt;

  // Compute the accept, push and issue decisions and the next occupancy and credit values.
  always_comb begin
    accept_c     = req_vld && req_rdy;
    push_c       = accept_c && ((req_op == OP_ADD) || (req_op == OP_SUB));
    illegal_c    = accept_c && (req_op == OP_ILL);
    issue_c      = (fifo_count != '0) && (credit_cnt != '0);
    count_nxt    = fifo_count;
    credit_nxt   = credit_cnt;
    credit_ovf_c = 1'b0;

    if (push_c && !issue_c) begin
      count_nxt = fifo_count + CNT_W'(1);
    end else if (!push_c && issue_c) begin
      count_nxt = fifo_count - CNT_W'(1);
    end

    // A credit returned this cycle only takes effect from the next cycle onward.
    if (issue_c && !credit_ret) begin
      credit_nxt = credit_cnt - CRD_W'(1);
    end else if (credit_ret && !issue_c) begin
      if (credit_cnt == CRD_W'(CREDITS)) begin
        credit_ovf_c = 1'b1;
      end else begin
        credit_nxt = credit_cnt + CRD_W'(1);
      end
    end
  end

  // Write into the FIFO storage. The contents need no reset because the pointers qualify them.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_op[wr_ptr] <= req_op;
      mem_a[wr_ptr]  <= req_a;
      mem_b[wr_ptr]  <= req_b;
    end
  end

  // Update the pointers, counters, sticky error flags, ready flag and ALU issue registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      credit_cnt  <= CRD_W'(CREDITS);
      req_rdy     <= 1'b1;
      err_illegal <= 1'b0;
      err_credit  <= 1'b0;
      alu_vld     <= 1'b0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
    end else begin
      fifo_count <= count_nxt;
      credit_cnt <= credit_nxt;
      // The ready flag is registered from the next occupancy, so it always equals !full.
      req_rdy    <= (count_nxt != CNT_W'(DEPTH));

      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (illegal_c) begin
        err_illegal <= 1'b1;
      end
      if (credit_ovf_c) begin
        err_credit <= 1'b1;
      end

      if (issue_c) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        alu_vld <= 1'b1;
        alu_op  <= mem_op[rd_ptr];
        alu_a   <= mem_a[rd_ptr];
        alu_b   <= mem_b[rd_ptr];
      end else begin
        alu_vld <= 1'b0;
        alu_op  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl. Expected ALU transactions are queued
// when they are driven. A negedge monitor pops and compares them on every alu_vld.
module tb_alu_issue_ctrl;

  localparam int unsigned WIDTH   = 6;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CREDITS = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_vld;
  logic             req_rdy;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             alu_vld;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             credit_ret;
  logic [2:0]       fifo_count;
  logic [2:0]       credit_cnt;
  logic             err_illegal;
  logic             err_credit;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } txn_t;

  txn_t sb[$];
  txn_t mon_exp;
  int   total  = 0;
  int   bad    = 0;
  int   issues = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CREDITS(CREDITS)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_vld(alu_vld), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .credit_ret(credit_ret), .fifo_count(fifo_count), .credit_cnt(credit_cnt),
    .err_illegal(err_illegal), .err_credit(err_credit)
  );

  // Scoreboard monitor: compare every issued transaction with the oldest expected one.
  always @(negedge clk) begin
    if (!rst && alu_vld === 1'b1) begin
      issues++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: issued op=%0d a=%0d b=%0d, required no issue", alu_op, alu_a, alu_b);
      end else begin
        mon_exp = sb.pop_front();
        if ({alu_op, alu_a, alu_b} !== mon_exp) begin
          bad++;
          $display("FAIL sb_payload: got op=%0d a=%0d b=%0d, required op=%0d a=%0d b=%0d",
                   alu_op, alu_a, alu_b, mon_exp.op, mon_exp.a, mon_exp.b);
        end
      end
    end
  end

  // Global time bound so the bench never hangs.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_vld = 1'b0; credit_ret = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    step();
    sb.delete();
    rst = 1'b0;
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    txn_t t;
    req_vld = 1'b1; req_op = op; req_a = a; req_b = b;
    if (op == 2'd1 || op == 2'd2) begin
      t.op = op; t.a = a; t.b = b;
      sb.push_back(t);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (alu_vld !== 1'b0 || alu_op !== 2'd0 || alu_a !== 6'd0 || alu_b !== 6'd0) begin
      bad++; $display("FAIL reset_alu: got vld=%0d op=%0d a=%0d b=%0d, required all 0", alu_vld, alu_op, alu_a, alu_b); end
    total++; if (fifo_count !== 3'd0 || credit_cnt !== 3'd4) begin
      bad++; $display("FAIL reset_counts: got fifo=%0d credit=%0d, required 0 and 4", fifo_count, credit_cnt); end
    total++; if (req_rdy !== 1'b1 || err_illegal !== 1'b0 || err_credit !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got rdy=%0d ill=%0d crd=%0d, required 1 0 0", req_rdy, err_illegal, err_credit); end
  endtask

  task automatic test_single();
    do_reset();
    drive_req(2'd1, 6'd5, 6'd3);
    step();
    req_vld = 1'b0;
    total++; if (alu_vld !== 1'b0 || fifo_count !== 3'd1) begin
      bad++; $display("FAIL single_e1: got vld=%0d fifo=%0d, required 0 and 1", alu_vld, fifo_count); end
    step();
    total++; if (alu_vld !== 1'b1 || alu_op !== 2'd1 || alu_a !== 6'd5 || alu_b !== 6'd3) begin
      bad++; $display("FAIL single_e2: got vld=%0d op=%0d a=%0d b=%0d, required 1 1 5 3", alu_vld, alu_op, alu_a, alu_b); end
    total++; if (credit_cnt !== 3'd3 || fifo_count !== 3'd0) begin
      bad++; $display("FAIL single_cnt: got credit=%0d fifo=%0d, required 3 and 0", credit_cnt, fifo_count); end
    step();
    total++; if (alu_vld !== 1'b0 || alu_op !== 2'd0 || alu_a !== 6'd5 || alu_b !== 6'd3) begin
      bad++; $display("FAIL single_idle: got vld=%0d op=%0d a=%0d b=%0d, required 0 0 5 3", alu_vld, alu_op, alu_a, alu_b); end
  endtask

  task automatic test_back_to_back();
    logic [6:1] seen;
    int base;
    do_reset();
    base = issues;
    for (int i = 1; i <= 6; i++) begin
      drive_req(2'd2, WIDTH'(i * 7), WIDTH'(i));
      step();
      seen[i] = alu_vld;
    end
    req_vld = 1'b0;
    total++; if (seen !== 6'b011110) begin
      bad++; $display("FAIL b2b_pattern: got vld per edge=%b, required 011110", seen); end
    repeat (3) step();
    total++; if (fifo_count !== 3'd2 || credit_cnt !== 3'd0 || alu_vld !== 1'b0) begin
      bad++; $display("FAIL b2b_stall: got fifo=%0d credit=%0d vld=%0d, required 2 0 0", fifo_count, credit_cnt, alu_vld); end
    total++; if (issues - base != 4 || sb.size() != 2) begin
      bad++; $display("FAIL b2b_count: got issues=%0d pending=%0d, required 4 and 2", issues - base, sb.size()); end
    for (int k = 0; k < 2; k++) begin
      credit_ret = 1'b1;
      step();
      credit_ret = 1'b0;
      total++; if (alu_vld !== 1'b0 || credit_cnt !== 3'd1) begin
        bad++; $display("FAIL b2b_ret%0d: got vld=%0d credit=%0d, required 0 and 1", k, alu_vld, credit_cnt); end
      step();
      total++; if (alu_vld !== 1'b1 || credit_cnt !== 3'd0 || fifo_count !== 3'(1 - k)) begin
        bad++; $display("FAIL b2b_issue%0d: got vld=%0d credit=%0d fifo=%0d, required 1 0 %0d", k, alu_vld, credit_cnt, fifo_count, 1 - k); end
    end
    step();
    total++; if (sb.size() != 0 || issues - base != 6) begin
      bad++; $display("FAIL b2b_drain: got pending=%0d issues=%0d, required 0 and 6", sb.size(), issues - base); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_req(2'd1, WIDTH'(i), WIDTH'(i + 20));
      step();
    end
    req_vld = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 4; i++) begin
      drive_req(2'd2, WIDTH'(40 + i), WIDTH'(i + 1));
      step();
    end
    req_vld = 1'b0;
    total++; if (fifo_count !== 3'd4 || req_rdy !== 1'b0 || credit_cnt !== 3'd0) begin
      bad++; $display("FAIL fill_full: got fifo=%0d rdy=%0d credit=%0d, required 4 0 0", fifo_count, req_rdy, credit_cnt); end
    // A fifth request while full must be refused; it is not queued as expected.
    req_vld = 1'b1; req_op = 2'd1; req_a = 6'd33; req_b = 6'd33;
    step();
    req_vld = 1'b0;
    total++; if (fifo_count !== 3'd4 || req_rdy !== 1'b0) begin
      bad++; $display("FAIL fill_refuse: got fifo=%0d rdy=%0d, required 4 and 0", fifo_count, req_rdy); end
    credit_ret = 1'b1;
    step();
    credit_ret = 1'b0;
    total++; if (req_rdy !== 1'b0 || credit_cnt !== 3'd1 || alu_vld !== 1'b0) begin
      bad++; $display("FAIL fill_ret: got rdy=%0d credit=%0d vld=%0d, required 0 1 0", req_rdy, credit_cnt, alu_vld); end
    step();
    total++; if (alu_vld !== 1'b1 || fifo_count !== 3'd3 || req_rdy !== 1'b1) begin
      bad++; $display("FAIL fill_pop: got vld=%0d fifo=%0d rdy=%0d, required 1 3 1", alu_vld, fifo_count, req_rdy); end
    repeat (3) begin
      credit_ret = 1'b1;
      step();
      credit_ret = 1'b0;
      step();
    end
    step();
    total++; if (fifo_count !== 3'd0 || sb.size() != 0) begin
      bad++; $display("FAIL fill_drain: got fifo=%0d pending=%0d, required 0 and 0", fifo_count, sb.size()); end
  endtask

  task automatic test_filter();
    int base;
    do_reset();
    base = issues;
    drive_req(2'd0, 6'd1, 6'd2);
    step();
    total++; if (err_illegal !== 1'b0 || fifo_count !== 3'd0) begin
      bad++; $display("FAIL filt_nop: got ill=%0d fifo=%0d, required 0 and 0", err_illegal, fifo_count); end
    drive_req(2'd3, 6'd4, 6'd5);
    step();
    total++; if (err_illegal !== 1'b1 || fifo_count !== 3'd0) begin
      bad++; $display("FAIL filt_ill: got ill=%0d fifo=%0d, required 1 and 0", err_illegal, fifo_count); end
    drive_req(2'd1, 6'd63, 6'd1);
    step();
    req_vld = 1'b0;
    total++; if (fifo_count !== 3'd1) begin
      bad++; $display("FAIL filt_push: got fifo=%0d, required 1", fifo_count); end
    step();
    total++; if (alu_vld !== 1'b1 || alu_a !== 6'd63 || alu_b !== 6'd1 || credit_cnt !== 3'd3) begin
      bad++; $display("FAIL filt_issue: got vld=%0d a=%0d b=%0d credit=%0d, required 1 63 1 3", alu_vld, alu_a, alu_b, credit_cnt); end
    repeat (3) step();
    total++; if (issues - base != 1 || credit_cnt !== 3'd3 || err_illegal !== 1'b1) begin
      bad++; $display("FAIL filt_end: got issues=%0d credit=%0d ill=%0d, required 1 3 1", issues - base, credit_cnt, err_illegal); end
  endtask

  task automatic test_credit_overflow();
    do_reset();
    credit_ret = 1'b1;
    step();
    credit_ret = 1'b0;
    total++; if (credit_cnt !== 3'd4 || err_credit !== 1'b1) begin
      bad++; $display("FAIL ovf_set: got credit=%0d err=%0d, required 4 and 1", credit_cnt, err_credit); end
    step();
    total++; if (err_credit !== 1'b1) begin
      bad++; $display("FAIL ovf_sticky: got err=%0d, required 1", err_credit); end
    // A return that coincides with an issue at full credit is not an overflow.
    do_reset();
    drive_req(2'd1, 6'd7, 6'd9);
    step();
    req_vld = 1'b0;
    credit_ret = 1'b1;
    step();
    credit_ret = 1'b0;
    total++; if (alu_vld !== 1'b1 || credit_cnt !== 3'd4 || err_credit !== 1'b0) begin
      bad++; $display("FAIL ovf_issue: got vld=%0d credit=%0d err=%0d, required 1 4 0", alu_vld, credit_cnt, err_credit); end
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    drive_req(2'd3, 6'd0, 6'd0);
    step();
    for (int i = 0; i < 6; i++) begin
      drive_req(2'd2, WIDTH'(10 + i), WIDTH'(i));
      step();
    end
    req_vld = 1'b0;
    repeat (2) step();
    credit_ret = 1'b1;
    step();
    credit_ret = 1'b0;
    total++; if (credit_cnt !== 3'd1 || fifo_count !== 3'd2 || err_illegal !== 1'b1) begin
      bad++; $display("FAIL mid_pre: got credit=%0d fifo=%0d ill=%0d, required 1 2 1", credit_cnt, fifo_count, err_illegal); end
    // Reset arrives together with a credit return, which must be ignored.
    rst = 1'b1; credit_ret = 1'b1;
    step();
    sb.delete();
    rst = 1'b0; credit_ret = 1'b0;
    base = issues;
    total++; if (alu_vld !== 1'b0 || fifo_count !== 3'd0 || credit_cnt !== 3'd4 || req_rdy !== 1'b1) begin
      bad++; $display("FAIL mid_rst: got vld=%0d fifo=%0d credit=%0d rdy=%0d, required 0 0 4 1", alu_vld, fifo_count, credit_cnt, req_rdy); end
    total++; if (err_illegal !== 1'b0 || err_credit !== 1'b0 || alu_a !== 6'd0 || alu_op !== 2'd0) begin
      bad++; $display("FAIL mid_flags: got ill=%0d crd=%0d a=%0d op=%0d, required 0 0 0 0", err_illegal, err_credit, alu_a, alu_op); end
    repeat (4) step();
    total++; if (issues != base || fifo_count !== 3'd0) begin
      bad++; $display("FAIL mid_quiet: got issues=%0d fifo=%0d, required 0 and 0", issues - base, fifo_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_filter();
    test_credit_overflow();
    test_reset_mid();
    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue stage directly upstream of the two-cycle registered ALU (add/sub, `vld`-qualified, no backpressure).
- Accepts operation requests on a valid/ready interface and buffers them in a small FIFO.
- Issues at most one request per cycle to the ALU, gated by a credit counter. The counter is replenished by the downstream result consumer, so ALU results never overrun the downstream buffer.

Parameters:
- WIDTH, 6, operand width; matches ALU WIDTH.
- DEPTH, 4, request FIFO entries; power of two, ≥2.
- CREDITS, 4, downstream result slots; initial and maximum credit count, ≥1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- req_vld  in  1  request valid.
- req_rdy  out  1  FIFO can accept; equals !full.
- req_op  in  2  0=nop, 1=add, 2=sub, 3=illegal.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- alu_vld  out  1  registered issue strobe to ALU `vld`.
- alu_op  out  2  registered op to ALU `op_in`.
- alu_a  out  WIDTH  registered operand A.
- alu_b  out  WIDTH  registered operand B.
- credit_ret  in  1  one-cycle pulse: downstream freed one result slot.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- credit_cnt  out  $clog2(CREDITS)+1  credits available.
- err_illegal  out  1  sticky: op 3 request accepted.
- err_credit  out  1  sticky: credit_ret received with credit_cnt==CREDITS.

Behaviour:
- Reset values (synchronous):
  - alu_vld=0, alu_op=0, alu_a=0, alu_b=0.
  - fifo_count=0, credit_cnt=CREDITS.
  - err_illegal=0, err_credit=0.
  - FIFO pointers=0; req_rdy=1 in the first cycle after reset.
  - Reset mid-operation discards all FIFO contents and in-flight accounting. A credit_ret in the same cycle as rst is ignored.
- Accept: a request is taken on an edge with req_vld && req_rdy.
  - req_rdy depends only on registered state (fifo_count != DEPTH), never combinationally on issue.
  - A full FIFO therefore refuses a push even if it pops the same cycle.
- Filtering at accept:
  - op 1 and op 2 are pushed.
  - op 0 is accepted and dropped silently.
  - op 3 is accepted, dropped, and sets err_illegal, which holds until rst.
  - Dropped requests consume no FIFO entry and no credit.
- Issue condition (evaluated each cycle): fifo_count != 0 && credit_cnt != 0.
  - When true, the head is popped on that edge.
  - alu_vld=1, alu_op, alu_a and alu_b are loaded from the head.
- When no issue occurs:
  - alu_vld=0 and alu_op=0.
  - alu_a and alu_b hold their last values.
- No bypass: an entry accepted at edge E0 is popped at edge E1 at the earliest, so alu_vld is high in the cycle after E1.
  - Minimum request-to-alu_vld latency is 2 edges.
  - Sustained throughput is 1 issue per cycle.
- Ordering is strict FIFO. Pointers wrap modulo DEPTH.
- fifo_count:
  - +1 on push only, −1 on pop only.
  - Unchanged on simultaneous push+pop (possible only when not full).
- credit_cnt:
  - −1 on issue only, +1 on credit_ret only.
  - Unchanged on simultaneous issue+credit_ret.
  - A credit returned in a cycle is usable for issue on the next cycle, not the same cycle.
- Credit overflow: credit_ret while credit_cnt==CREDITS and no issue that cycle leaves credit_cnt unchanged and sets err_credit (sticky).
  - If an issue occurs in the same cycle, the net effect is unchanged count and no error.
- Underflow cannot occur, because issue is gated by credit_cnt != 0.

Test Plan:
- Reset then single add (req_op=1, a=5, b=3) at edge 1 → alu_vld=1 with alu_op=1, alu_a=5, alu_b=3 only in the cycle after edge 2; credit_cnt 4→3; fifo_count back to 0.
- 6 back-to-back sub requests, no credit_ret → exactly 4 issues on consecutive cycles. Remaining 2 stay in the FIFO; credit_cnt=0; alu_vld=0 thereafter.
- Then pulse credit_ret twice → the 2 remaining requests issue in order, each one cycle after its credit_ret edge.
- Fill: hold credit_cnt=0 and push 4 requests → fifo_count=4, req_rdy=0. A 5th req_vld is not accepted. After one credit_ret, the pop occurs, and req_rdy=1 the following cycle.
- Filtering: requests op=0, op=3, op=1 (a=63, b=1) → only the op=1 request issues (alu_a=63, alu_b=1); err_illegal=1 from the edge accepting op=3; credit_cnt decrements once.
- Credit overflow: at reset state pulse credit_ret with the FIFO empty → credit_cnt stays 4 and err_credit=1. Apply rst while entries are queued and credit_cnt=1 → all outputs return to reset values the next cycle and queued entries never issue.
